native_memory_pipelined: RTL
============================

NATIVE_MEMORY_PIPELINED -- requirements
Module: native_memory_pipelined

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8, >=8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL provide parameter DEPTH, default 1024, number of DATA_WIDTH words (power of 2).
REQ-004 SHALL provide parameter READ_LATENCY, default 2, cycles from address accept to data availability (>=1).
REQ-005 SHALL provide parameter MAX_OUTSTANDING, default 4, reads in flight plus queued (power of 2, >=READ_LATENCY).
REQ-006 SHALL provide ports clk input 1 and rst input 1; one clock; reset asynchronous, active-high.
REQ-007 SHALL provide raddr_valid input 1 and raddr input ADDR_WIDTH: read request.
REQ-008 SHALL provide raddr_ready output 1: read request accepted when high with raddr_valid.
REQ-009 SHALL provide rdata_valid output 1 and rdata output DATA_WIDTH: read response.
REQ-010 SHALL provide rdata_ready input 1: response consumed when high with rdata_valid.
REQ-011 SHALL provide w_valid input 1, waddr input ADDR_WIDTH, wdata input DATA_WIDTH, wstrb input DATA_WIDTH/8: write request with byte enables.
REQ-012 SHALL provide w_ready output 1: write accepted when high with w_valid.

Function
REQ-013 SHALL index memory with word = addr[log2(DATA_WIDTH/8) +: log2(DEPTH)]; low byte-offset bits and upper bits ignored, so out-of-range addresses wrap.
REQ-014 SHALL accept a read on any rising edge where raddr_valid && raddr_ready.
REQ-015 SHALL keep outstanding count = reads accepted minus responses consumed; raddr_ready = (count < MAX_OUTSTANDING).
REQ-016 SHALL keep count unchanged on a cycle with both an accept and a consume, including when count == MAX_OUTSTANDING (raddr_ready low, so no accept occurs that cycle; accept possible the next).
REQ-017 SHALL sample memory at accept edge; data enters a READ_LATENCY-stage valid-tagged pipeline, then an in-order response FIFO of MAX_OUTSTANDING entries.
REQ-018 SHALL assert rdata_valid exactly READ_LATENCY cycles after accept edge when FIFO empty and rdata_ready high throughout; back-to-back accepts yield back-to-back responses, one per cycle.
REQ-019 SHALL hold rdata_valid and rdata stable while rdata_valid && !rdata_ready; pipeline keeps advancing into FIFO; FIFO never overflows, guaranteed by REQ-015.
REQ-020 SHALL return responses strictly in accept order.
REQ-021 SHALL hold w_ready = 1 whenever not in reset; write completes at the accept edge, updating only bytes with wstrb[i]=1; wstrb = 0 writes nothing.
REQ-022 SHALL give read-before-write on same-edge read accept and write to the same word: read returns old data; a read accepted on any later edge returns new data.
REQ-023 SHALL ignore raddr/waddr/wdata/wstrb when corresponding valid is low.

Reset
REQ-024 SHALL, while rst high, drive raddr_ready=0, w_ready=0, rdata_valid=0, rdata=0; clear count, pipeline valid bits and FIFO pointers.
REQ-025 SHALL discard in-flight reads and queued responses on reset mid-operation; no response for them after release.
REQ-026 SHALL NOT reset memory contents; contents persist across reset.
REQ-027 SHALL drive raddr_ready=1 and w_ready=1 on the first cycle after rst deasserts.

Verification
REQ-028 Write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> rdata=0xDEADBEEF, rdata_valid exactly 2 cycles after accept.
REQ-029 Word 0x20 = 0x11223344, write 0xAABBCCDD with wstrb=0x5, read -> 0x11BB33DD.
REQ-030 rdata_ready=0, issue reads to 0x0,0x4,0x8,0xC,0x10 -> four accepted, raddr_ready=0 on fifth; raise rdata_ready -> four in order, then fifth accepted.
REQ-031 Same-edge read and write to 0x40 (old 0x1, new 0x2) -> read returns 0x1; next read returns 0x2.
REQ-032 Assert rst with 3 reads outstanding -> outputs 0 during reset, no stale rdata_valid after release, raddr_ready=1 first cycle after release.
REQ-033 Read 0x1000 with DEPTH=1024, DATA_WIDTH=32 -> returns word 0 contents (address wrap).

Source files
------------

// File: rtl/native_memory_pipelined.sv
// Byte-addressed single-port-style memory with a pipelined, back-pressured read
// channel (valid-tagged latency pipeline feeding an in-order response FIFO).
module native_memory_pipelined #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 1024,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    raddr_valid,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic                    raddr_ready,
    output logic                    rdata_valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rdata_ready,
    input  logic                    w_valid,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    w_ready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]        ridx, widx;
    logic                    rd_accept, wr_accept, rd_consume;
    logic [CNT_W-1:0]        count;
    logic [READ_LATENCY-1:0] stage_valid;
    logic [DATA_WIDTH-1:0]   stage_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   fifo_mem [MAX_OUTSTANDING];
    logic [CNT_W-1:0]        wptr, rptr;
    logic                    unused_addr_bits;

    // Upper and byte-offset address bits are dropped, so addresses wrap.
    assign ridx             = raddr[OFF_W +: IDX_W];
    assign widx             = waddr[OFF_W +: IDX_W];
    assign unused_addr_bits = ^{raddr, waddr};

    assign raddr_ready = !rst && (count < CNT_W'(MAX_OUTSTANDING));
    assign w_ready     = !rst;
    assign rd_accept   = raddr_valid && raddr_ready;
    assign wr_accept   = w_valid && w_ready;
    assign rd_consume  = rdata_valid && rdata_ready;

    assign rdata_valid = (wptr != rptr);
    assign rdata       = rdata_valid ? fifo_mem[rptr[PTR_W-1:0]] : '0;

    // Counting accepted-but-unconsumed reads bounds the FIFO occupancy, so it cannot overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            count <= '0;
        end else if (rd_accept && !rd_consume) begin
            count <= count + 1'b1;
        end else if (!rd_accept && rd_consume) begin
            count <= count - 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; contents survive rst and only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Same-edge read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (rd_accept) stage_data[0] <= mem[ridx];
        for (int i = 1; i < READ_LATENCY; i++) stage_data[i] <= stage_data[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) stage_valid[i] <= stage_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (stage_valid[READ_LATENCY-1]) fifo_mem[wptr[PTR_W-1:0]] <= stage_data[READ_LATENCY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (stage_valid[READ_LATENCY-1]) wptr <= wptr + 1'b1;
            if (rd_consume)                  rptr <= rptr + 1'b1;
        end
    end

endmodule
